// File: rtl/sdram_arbit.sv
// sdram_arbit: command arbiter between init, auto-refresh, write and read blocks.
// Optional feature macro: SDRAM_ARBIT_RR_EN (round-robin between write and read;
// refresh stays highest priority). Undefined: fixed priority ar > wr > rd.
module sdram_arbit #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13,
  parameter int BANK_WIDTH = 2
) (
  input  logic                  arbit_clk,
  input  logic                  arbit_rst_n,
  input  logic                  init_end,
  input  logic [3:0]            init_cmd,
  input  logic [BANK_WIDTH-1:0] init_bank,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic                  ar_req,
  input  logic                  ar_end,
  input  logic [3:0]            ar_cmd,
  input  logic [BANK_WIDTH-1:0] ar_bank,
  input  logic [ADDR_WIDTH-1:0] ar_addr,
  output logic                  ar_en,
  input  logic                  wr_req,
  input  logic                  wr_end,
  input  logic [3:0]            wr_cmd,
  input  logic [BANK_WIDTH-1:0] wr_bank,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  wr_sdram_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  input  logic                  rd_req,
  input  logic                  rd_end,
  input  logic [3:0]            rd_cmd,
  input  logic [BANK_WIDTH-1:0] rd_bank,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  output logic [3:0]            sdram_cmd,
  output logic [BANK_WIDTH-1:0] sdram_bank,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  inout  wire  [DATA_WIDTH-1:0] sdram_dq
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARBIT = 3'd1,
    AREF  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4
  } state_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;

  state_t state_q, state_d;
  logic   ar_en_q, ar_en_d;
  logic   wr_en_q, wr_en_d;
  logic   rd_en_q, rd_en_d;
`ifdef SDRAM_ARBIT_RR_EN
  logic   last_wr_q, last_wr_d;
`endif

  // Next-state and grant selection; enables track the state being entered.
  always_comb begin
    state_d = state_q;
`ifdef SDRAM_ARBIT_RR_EN
    last_wr_d = last_wr_q;
`endif
    case (state_q)
      IDLE:  if (init_end) state_d = ARBIT;
      ARBIT: begin
        if (ar_req)
          state_d = AREF;
`ifdef SDRAM_ARBIT_RR_EN
        else if (wr_req && rd_req)
          state_d = last_wr_q ? READ : WRITE;
`endif
        else if (wr_req)
          state_d = WRITE;
        else if (rd_req)
          state_d = READ;
      end
      AREF:    if (ar_end) state_d = ARBIT;
      WRITE:   if (wr_end) state_d = ARBIT;
      READ:    if (rd_end) state_d = ARBIT;
      default: state_d = IDLE;
    endcase
`ifdef SDRAM_ARBIT_RR_EN
    if (state_q == ARBIT && state_d == WRITE) last_wr_d = 1'b1;
    if (state_q == ARBIT && state_d == READ)  last_wr_d = 1'b0;
`endif
    ar_en_d = (state_d == AREF);
    wr_en_d = (state_d == WRITE);
    rd_en_d = (state_d == READ);
  end

  // State and registered grant enables.
  always_ff @(posedge arbit_clk or negedge arbit_rst_n) begin
    if (!arbit_rst_n) begin
      state_q   <= IDLE;
      ar_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
`ifdef SDRAM_ARBIT_RR_EN
      last_wr_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ar_en_q   <= ar_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
`ifdef SDRAM_ARBIT_RR_EN
      last_wr_q <= last_wr_d;
`endif
    end
  end

  assign ar_en = ar_en_q;
  assign wr_en = wr_en_q;
  assign rd_en = rd_en_q;

  // Pin mux driven from the registered state.
  always_comb begin
    sdram_cmd  = init_cmd;
    sdram_bank = init_bank;
    sdram_addr = init_addr;
    case (state_q)
      IDLE: begin
        sdram_cmd  = init_cmd;
        sdram_bank = init_bank;
        sdram_addr = init_addr;
      end
      AREF: begin
        sdram_cmd  = ar_cmd;
        sdram_bank = ar_bank;
        sdram_addr = ar_addr;
      end
      WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_bank = wr_bank;
        sdram_addr = wr_addr;
      end
      READ: begin
        sdram_cmd  = rd_cmd;
        sdram_bank = rd_bank;
        sdram_addr = rd_addr;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_bank = '1;
        sdram_addr = '1;
      end
    endcase
  end

  assign sdram_dq = (state_q == WRITE && wr_sdram_en) ? wr_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: directed bench for sdram_arbit (default and SDRAM_ARBIT_RR_EN builds).
module tb_sdram_arbit;

  localparam int DW = 16;
  localparam int AW = 13;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_end;
  logic [3:0]    init_cmd, ar_cmd, wr_cmd, rd_cmd;
  logic [BW-1:0] init_bank, ar_bank, wr_bank, rd_bank;
  logic [AW-1:0] init_addr, ar_addr, wr_addr, rd_addr;
  logic          ar_req, ar_end, wr_req, wr_end, rd_req, rd_end;
  logic          wr_sdram_en;
  logic [DW-1:0] wr_data;
  logic          ar_en, wr_en, rd_en;
  logic [3:0]    sdram_cmd;
  logic [BW-1:0] sdram_bank;
  logic [AW-1:0] sdram_addr;
  wire  [DW-1:0] dq_w;

  // The bench plays the chip: when it drives, a released DUT lets the bench value through.
  logic          tb_oe;
  logic [DW-1:0] tb_dq;
  assign dq_w = tb_oe ? tb_dq : {DW{1'bz}};

  int checks = 0;
  int errors = 0;

  localparam logic [15:0] CHIP_VAL = 16'h5AA5;
  localparam logic [2:0]  EN_NONE  = 3'b000;
  localparam logic [2:0]  EN_AR    = 3'b100;
  localparam logic [2:0]  EN_WR    = 3'b010;
  localparam logic [2:0]  EN_RD    = 3'b001;

  sdram_arbit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BANK_WIDTH(BW)) dut (
    .arbit_clk(clk), .arbit_rst_n(rst_n), .init_end(init_end),
    .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
    .ar_req(ar_req), .ar_end(ar_end), .ar_cmd(ar_cmd), .ar_bank(ar_bank),
    .ar_addr(ar_addr), .ar_en(ar_en),
    .wr_req(wr_req), .wr_end(wr_end), .wr_cmd(wr_cmd), .wr_bank(wr_bank),
    .wr_addr(wr_addr), .wr_sdram_en(wr_sdram_en), .wr_data(wr_data), .wr_en(wr_en),
    .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_bank(rd_bank),
    .rd_addr(rd_addr), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank), .sdram_addr(sdram_addr),
    .sdram_dq(dq_w)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic [2:0] en,
                         input logic [3:0] cmd, input logic [BW-1:0] bank,
                         input logic [AW-1:0] addr);
    chk({tag, "_en"},   {29'd0, ar_en, wr_en, rd_en}, {29'd0, en});
    chk({tag, "_cmd"},  {28'd0, sdram_cmd}, {28'd0, cmd});
    chk({tag, "_bank"}, {30'd0, sdram_bank}, {30'd0, bank});
    chk({tag, "_addr"}, {19'd0, sdram_addr}, {19'd0, addr});
  endtask

  task automatic chk_nop(input string tag);
    chk_bus(tag, EN_NONE, 4'b0111, 2'b11, 13'h1FFF);
  endtask

  task automatic chk_dq(input string tag, input logic [DW-1:0] exp);
    chk(tag, {16'd0, dq_w}, {16'd0, exp});
  endtask

  logic exp_wr_seq [3];

  initial begin
    rst_n = 1'b0; init_end = 1'b0;
    init_cmd = 4'b0010; init_bank = 2'b01; init_addr = 13'h0400;
    ar_cmd   = 4'b0001; ar_bank   = 2'b10; ar_addr   = 13'h1111;
    wr_cmd   = 4'b0100; wr_bank   = 2'b11; wr_addr   = 13'h0ABC;
    rd_cmd   = 4'b0101; rd_bank   = 2'b00; rd_addr   = 13'h0123;
    ar_req = 0; ar_end = 0; wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
    wr_sdram_en = 0; wr_data = 16'hA55A;
    tb_oe = 1'b1; tb_dq = CHIP_VAL;
`ifdef SDRAM_ARBIT_RR_EN
    exp_wr_seq[0] = 1'b1; exp_wr_seq[1] = 1'b0; exp_wr_seq[2] = 1'b1;
`else
    exp_wr_seq[0] = 1'b1; exp_wr_seq[1] = 1'b1; exp_wr_seq[2] = 1'b1;
`endif

    // 1: reset and IDLE with init_end low
    step(); step();
    chk_bus("rst", EN_NONE, 4'b0010, 2'b01, 13'h0400);
    chk_dq("rst_dq", CHIP_VAL);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk_bus("idle", EN_NONE, 4'b0010, 2'b01, 13'h0400);
    chk_dq("idle_dq", CHIP_VAL);

    // 2: init done, then a single refresh
    init_end = 1'b1;
    step();
    chk_nop("arbit0");
    ar_req = 1'b1;
    step();
    chk_bus("aref", EN_AR, 4'b0001, 2'b10, 13'h1111);
    ar_req = 1'b0; ar_end = 1'b1;
    step();
    ar_end = 1'b0;
    chk_nop("aref_done");

    // 3: simultaneous requests -> AREF, NOP, WRITE, NOP, READ, NOP
    ar_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    step();
    chk_bus("t3_aref", EN_AR, 4'b0001, 2'b10, 13'h1111);
    ar_req = 1'b0; ar_end = 1'b1;
    step();
    ar_end = 1'b0;
    chk_nop("t3_gap1");
    step();
    chk_bus("t3_wr", EN_WR, 4'b0100, 2'b11, 13'h0ABC);
    wr_req = 1'b0; wr_end = 1'b1;
    step();
    wr_end = 1'b0;
    chk_nop("t3_gap2");
    step();
    chk_bus("t3_rd", EN_RD, 4'b0101, 2'b00, 13'h0123);
    rd_req = 1'b0; rd_end = 1'b1;
    step();
    rd_end = 1'b0;
    chk_nop("t3_gap3");

    // stray end pulses in ARBIT are ignored
    wr_end = 1'b1; ar_end = 1'b1;
    step();
    wr_end = 1'b0; ar_end = 1'b0;
    chk_nop("stray_end");

    // 4 + 5: refresh raised mid-write waits; DQ driven only while writing with wr_sdram_en
    wr_req = 1'b1;
    step();
    chk_bus("t4_wr", EN_WR, 4'b0100, 2'b11, 13'h0ABC);
    wr_req = 1'b0; ar_req = 1'b1; rd_req = 1'b1;
    step();
    chk_bus("t4_nopreempt", EN_WR, 4'b0100, 2'b11, 13'h0ABC);
    tb_oe = 1'b0; wr_sdram_en = 1'b1;
    #1;
    chk_dq("dq_drive", 16'hA55A);
    wr_sdram_en = 1'b0; tb_oe = 1'b1;
    #1;
    chk_dq("dq_release", CHIP_VAL);
    rd_end = 1'b1;
    step();
    rd_end = 1'b0;
    chk("t4_rdend_ignored", {31'd0, wr_en}, 32'd1);
    wr_end = 1'b1;
    step();
    wr_end = 1'b0;
    chk_nop("t4_gap1");
    step();
    chk_bus("t4_aref_first", EN_AR, 4'b0001, 2'b10, 13'h1111);
    ar_req = 1'b0; ar_end = 1'b1;
    step();
    ar_end = 1'b0;
    chk_nop("t4_gap2");
    step();
    chk_bus("t4_rd", EN_RD, 4'b0101, 2'b00, 13'h0123);
    rd_req = 1'b0; wr_sdram_en = 1'b1;
    #1;
    chk_dq("dq_read_z", CHIP_VAL);
    wr_sdram_en = 1'b0; rd_end = 1'b1;
    step();
    rd_end = 1'b0;
    chk_nop("t4_gap3");

    // 6: write and read held together
    wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t6_grant%0d", i), {29'd0, ar_en, wr_en, rd_en},
          exp_wr_seq[i] ? {29'd0, EN_WR} : {29'd0, EN_RD});
      if (exp_wr_seq[i]) wr_end = 1'b1; else rd_end = 1'b1;
      step();
      wr_end = 1'b0; rd_end = 1'b0;
      chk_nop($sformatf("t6_gap%0d", i));
    end
    rd_req = 1'b0;

    // asynchronous reset mid-write
    step();
    chk("rst_mid_pre", {31'd0, wr_en}, 32'd1);
    wr_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_bus("rst_mid", EN_NONE, 4'b0010, 2'b01, 13'h0400);
    step();
    chk_bus("rst_hold", EN_NONE, 4'b0010, 2'b01, 13'h0400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
